crank_gen: RTL

CRANK_GEN -- requirements
Module: crank_gen

---
 rtl/crank_gen.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/crank_gen.sv
// Synthetic crank-wheel generator: N slots per revolution with G missing teeth
// at the end, each slot P clocks, real teeth high for the first H clocks.
module crank_gen #(
  parameter int PW = 16,
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic [PW-1:0] tooth_period,
  input  logic [PW-1:0] high_time,
  input  logic [TW-1:0] tooth_count,
  input  logic [TW-1:0] gap_count,
  output logic          vr_out,
  output logic [TW-1:0] tooth_num,
  output logic          tooth_stb,
  output logic          rev_stb,
  output logic          busy,
  output logic          cfg_err
);

  localparam logic [PW-1:0] ONE_P = PW'(1);
  localparam logic [PW-1:0] TWO_P = PW'(2);
  localparam logic [TW-1:0] ONE_T = TW'(1);
  localparam logic [TW-1:0] TWO_T = TW'(2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TOOTH = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t        r_state, w_state_next;
  logic [PW-1:0] r_per_cnt, w_per_cnt_next;
  logic [TW-1:0] r_tooth_num, w_tooth_num_next;
  logic [PW-1:0] r_p, r_h;
  logic [TW-1:0] r_n, r_g;
  logic          r_vr, r_tooth_stb, r_rev_stb, r_busy, r_cfg_err;
  logic          w_vr_next, w_tooth_stb_next, w_rev_stb_next, w_busy_next, w_cfg_err_next;
  logic          w_load, w_cfg_ok, w_last_cnt, w_last_slot;
  logic [TW-1:0] w_tooth_inc, w_n_real;
  logic [PW-1:0] w_h_eff;

  // Validity is judged on the live inputs: it only matters at start and wrap,
  // which are exactly the moments the shadows are loaded from those inputs.
  assign w_cfg_ok = (tooth_period >= TWO_P) && (high_time != '0) &&
                    (high_time < tooth_period) && (tooth_count >= TWO_T) &&
                    (gap_count < tooth_count);

  assign w_last_cnt  = (r_per_cnt == r_p - ONE_P);
  assign w_last_slot = (r_tooth_num == r_n - ONE_T);
  assign w_tooth_inc = r_tooth_num + ONE_T;
  assign w_n_real    = r_n - r_g;
  assign w_h_eff     = w_load ? high_time : r_h;

  // State register (also holds shadows and registered outputs)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_per_cnt   <= '0;
      r_tooth_num <= '0;
      r_p         <= '0;
      r_h         <= '0;
      r_n         <= '0;
      r_g         <= '0;
      r_vr        <= 1'b0;
      r_tooth_stb <= 1'b0;
      r_rev_stb   <= 1'b0;
      r_busy      <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_per_cnt   <= w_per_cnt_next;
      r_tooth_num <= w_tooth_num_next;
      if (w_load) begin
        r_p <= tooth_period;
        r_h <= high_time;
        r_n <= tooth_count;
        r_g <= gap_count;
      end
      r_vr        <= w_vr_next;
      r_tooth_stb <= w_tooth_stb_next;
      r_rev_stb   <= w_rev_stb_next;
      r_busy      <= w_busy_next;
      r_cfg_err   <= w_cfg_err_next;
    end
  end

  // Next-state logic; every decision to stop or wrap is taken on a slot's last clock
  always_comb begin
    w_state_next     = r_state;
    w_per_cnt_next   = r_per_cnt;
    w_tooth_num_next = r_tooth_num;
    w_load           = 1'b0;
    w_cfg_err_next   = r_cfg_err;
    case (r_state)
      S_IDLE: begin
        w_per_cnt_next   = '0;
        w_tooth_num_next = '0;
        if (ena) begin
          if (w_cfg_ok) begin
            w_state_next   = S_TOOTH;
            w_load         = 1'b1;
            w_cfg_err_next = 1'b0;
          end else begin
            w_cfg_err_next = 1'b1;
          end
        end
      end
      S_TOOTH, S_GAP: begin
        if (!w_last_cnt) begin
          w_per_cnt_next = r_per_cnt + ONE_P;
        end else begin
          w_per_cnt_next = '0;
          if (!ena) begin
            w_state_next     = S_IDLE;
            w_tooth_num_next = '0;
          end else if (w_last_slot) begin
            w_tooth_num_next = '0;
            if (w_cfg_ok) begin
              w_state_next = S_TOOTH;
              w_load       = 1'b1;
            end else begin
              w_state_next   = S_IDLE;
              w_cfg_err_next = 1'b1;
            end
          end else begin
            w_tooth_num_next = w_tooth_inc;
            w_state_next     = (w_tooth_inc < w_n_real) ? S_TOOTH : S_GAP;
          end
        end
      end
      default: begin
        w_state_next     = S_IDLE;
        w_per_cnt_next   = '0;
        w_tooth_num_next = '0;
      end
    endcase
  end

  // Output logic, evaluated on the next state so the outputs can be registered
  always_comb begin
    w_vr_next        = 1'b0;
    w_tooth_stb_next = 1'b0;
    w_rev_stb_next   = 1'b0;
    w_busy_next      = (w_state_next != S_IDLE);
    if (w_state_next == S_TOOTH) begin
      w_vr_next        = (w_per_cnt_next < w_h_eff);
      w_tooth_stb_next = (w_per_cnt_next == '0);
      w_rev_stb_next   = w_load;
    end
  end

  assign vr_out    = r_vr;
  assign tooth_num = r_tooth_num;
  assign tooth_stb = r_tooth_stb;
  assign rev_stb   = r_rev_stb;
  assign busy      = r_busy;
  assign cfg_err   = r_cfg_err;

endmodule
